mul_mips_top: RTL and testbench

Multi-cycle 32-bit MIPS processor core with a unified instruction/data memory. It executes one instruction per 3–5 clock cycles, sequenced by a control FSM, and shares a single ALU and a single memory port across all instruction phases. This is the top-level CPU block. `test_value` exposes a fixed memory word so benches can observe program results.

---
 rtl/mul_mips_top.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mul_mips_top.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mul_mips_top.sv
// Multi-cycle MIPS core: one shared ALU, one unified memory port, control FSM.
// Optional `MUL_MIPS_JUMP_EN enables the j instruction; otherwise opcode 000010 is a nop.

module mul_mips_mem #(
    parameter int unsigned idx_width = 8,
    parameter int unsigned mem_width = 32,
    parameter int unsigned mem_depth = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [idx_width-1:0] addr,
    input  logic [mem_width-1:0] wd,
    output logic [mem_width-1:0] rd,
    output logic [mem_width-1:0] test_value
);
    logic [mem_width-1:0] mem [0:mem_depth-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < mem_depth; i++) mem[i] <= '0;
        end else if (we) begin
            mem[addr] <= wd;
        end
    end

    assign rd         = mem[addr];
    assign test_value = mem[idx_width'(8'h54)];
endmodule

module mul_mips_regfile #(
    parameter int unsigned reg_add_width = 5,
    parameter int unsigned reg_width     = 32,
    parameter int unsigned reg_depth     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [reg_add_width-1:0] ra1,
    input  logic [reg_add_width-1:0] ra2,
    input  logic [reg_add_width-1:0] wa,
    input  logic [reg_width-1:0]     wd,
    output logic [reg_width-1:0]     rd1,
    output logic [reg_width-1:0]     rd2
);
    logic [reg_width-1:0] regs [0:reg_depth-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < reg_depth; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

module mul_mips_top #(
    parameter int unsigned opcode_width   = 6,
    parameter int unsigned function_width = 6,
    parameter int unsigned alu_op_width   = 2,
    parameter int unsigned alu_con_width  = 3,
    parameter int unsigned alu_width      = 32,
    parameter int unsigned pc_width       = 32,
    parameter int unsigned mem_add_width  = 32,
    parameter int unsigned mem_width      = 32,
    parameter int unsigned mem_depth      = 256,
    parameter int unsigned reg_add_width  = 5,
    parameter int unsigned reg_width      = 32,
    parameter int unsigned reg_depth      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [mem_width-1:0] test_value
);
    localparam int unsigned idx_width = ($clog2(mem_depth) < mem_add_width) ? $clog2(mem_depth) : mem_add_width;

    localparam logic [opcode_width-1:0] OP_RTYPE = 6'b000000;
    localparam logic [opcode_width-1:0] OP_LW    = 6'b100011;
    localparam logic [opcode_width-1:0] OP_SW    = 6'b101011;
    localparam logic [opcode_width-1:0] OP_BEQ   = 6'b000100;
    localparam logic [opcode_width-1:0] OP_ADDI  = 6'b001000;
    localparam logic [opcode_width-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

    state_t state, state_next;

    logic [pc_width-1:0]   pc, pc_next, jump_target;
    logic [mem_width-1:0]  ir, mdr, mem_rd;
    logic [reg_width-1:0]  a, b, rf_rd1, rf_rd2, rf_wd;
    logic [alu_width-1:0]  alu_out, alu_a, alu_b, alu_y, simm;
    logic [idx_width-1:0]  mem_idx;
    logic [reg_add_width-1:0] rf_wa;
    logic [opcode_width-1:0]  opcode;
    logic [function_width-1:0] funct;
    logic [alu_con_width-1:0]  alu_con;
    logic [alu_op_width-1:0]   alu_op;
    logic [1:0] alu_src_b, pc_src;
    logic alu_src_a, iord, mem_we, ir_we, mdr_we, ab_we, alu_out_we;
    logic pc_we, pc_branch, reg_we, reg_dst, mem_to_reg, zero;

    assign opcode      = ir[31:26];
    assign funct       = ir[5:0];
    assign simm        = {{16{ir[15]}}, ir[15:0]};
    assign jump_target = {pc[31:28], ir[25:0], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'b00;
        pc_src     = 2'd0;
        iord       = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        ab_we      = 1'b0;
        alu_out_we = 1'b0;
        pc_we      = 1'b0;
        pc_branch  = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state)
            FETCH: begin
                ir_we = 1'b1; alu_src_b = 2'd1; pc_we = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                // ALU is idle here, so the branch target is precomputed speculatively
                ab_we = 1'b1; alu_src_b = 2'd3; alu_out_we = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
`ifdef MUL_MIPS_JUMP_EN
                    OP_J:         state_next = JUMP;
`endif
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1; alu_src_b = 2'd2; alu_out_we = 1'b1;
                state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD:   begin iord = 1'b1; mdr_we = 1'b1; state_next = MEMWB; end
            MEMWB:   begin reg_we = 1'b1; mem_to_reg = 1'b1; state_next = FETCH; end
            MEMWR:   begin iord = 1'b1; mem_we = 1'b1; state_next = FETCH; end
            EXECUTE: begin
                alu_src_a = 1'b1; alu_op = 2'b10; alu_out_we = 1'b1;
                state_next = ALUWB;
            end
            ALUWB:   begin reg_we = 1'b1; reg_dst = 1'b1; state_next = FETCH; end
            BRANCH:  begin
                alu_src_a = 1'b1; alu_op = 2'b01; pc_branch = 1'b1; pc_src = 2'd1;
                state_next = FETCH;
            end
            ADDIEX:  begin
                alu_src_a = 1'b1; alu_src_b = 2'd2; alu_out_we = 1'b1;
                state_next = ADDIWB;
            end
            ADDIWB:  begin reg_we = 1'b1; state_next = FETCH; end
            JUMP:    begin pc_we = 1'b1; pc_src = 2'd2; state_next = FETCH; end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        alu_con = 3'b010;
        case (alu_op)
            2'b01: alu_con = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alu_con = 3'b110;
                    6'b100100: alu_con = 3'b000;
                    6'b100101: alu_con = 3'b001;
                    6'b101010: alu_con = 3'b111;
                    default:   alu_con = 3'b010;
                endcase
            end
            default: alu_con = 3'b010;
        endcase
    end

    assign alu_a = alu_src_a ? a : pc;

    always_comb begin
        case (alu_src_b)
            2'd0:    alu_b = b;
            2'd1:    alu_b = alu_width'(4);
            2'd2:    alu_b = simm;
            default: alu_b = {simm[alu_width-3:0], 2'b00};
        endcase
    end

    always_comb begin
        case (alu_con)
            3'b110:  alu_y = alu_a - alu_b;
            3'b000:  alu_y = alu_a & alu_b;
            3'b001:  alu_y = alu_a | alu_b;
            3'b111:  alu_y = ($signed(alu_a) < $signed(alu_b)) ? alu_width'(1) : '0;
            default: alu_y = alu_a + alu_b;
        endcase
    end

    assign zero = (alu_y == '0);

    always_comb begin
        case (pc_src)
            2'd1:    pc_next = alu_out;
            2'd2:    pc_next = jump_target;
            default: pc_next = alu_y;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= '0;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            if (pc_we || (pc_branch && zero)) pc <= pc_next;
            if (ir_we)      ir      <= mem_rd;
            if (mdr_we)     mdr     <= mem_rd;
            if (ab_we)      a       <= rf_rd1;
            if (ab_we)      b       <= rf_rd2;
            if (alu_out_we) alu_out <= alu_y;
        end
    end

    assign mem_idx = iord ? alu_out[idx_width-1:0] : pc[idx_width-1:0];
    assign rf_wa   = reg_dst ? ir[15:11] : ir[20:16];
    assign rf_wd   = mem_to_reg ? mdr : alu_out;

    mul_mips_mem #(
        .idx_width (idx_width),
        .mem_width (mem_width),
        .mem_depth (mem_depth)
    ) dm (
        .clk        (clk),
        .rst        (rst),
        .we         (mem_we),
        .addr       (mem_idx),
        .wd         (b),
        .rd         (mem_rd),
        .test_value (test_value)
    );

    mul_mips_regfile #(
        .reg_add_width (reg_add_width),
        .reg_width     (reg_width),
        .reg_depth     (reg_depth)
    ) rf (
        .clk (clk),
        .rst (rst),
        .we  (reg_we),
        .ra1 (ir[25:21]),
        .ra2 (ir[20:16]),
        .wa  (rf_wa),
        .wd  (rf_wd),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2)
    );
endmodule

// File: tb/tb_mul_mips_top.sv
// Directed program tests for mul_mips_top; programs are poked into dut.dm.mem
// right as reset is released, results read from PC, register file and test_value.

module tb_mul_mips_top;
    logic        clk;
    logic        rst;
    logic [31:0] test_value;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] prog [0:15];

    mul_mips_top dut (
        .clk        (clk),
        .rst        (rst),
        .test_value (test_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = '0;
    endtask

    // Hold reset two cycles, release on a falling edge and load the program
    // before the first rising edge, which performs the first FETCH.
    task automatic start_prog();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) dut.dm.mem[i*4] = prog[i];
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] reg_or_all();
        logic [31:0] acc = '0;
        for (int i = 0; i < 32; i++) acc |= dut.rf.regs[i];
        return acc;
    endfunction

    initial begin
        rst = 1'b0;
        clear_prog();
        repeat (3) @(negedge clk);
        check("reset_pc",    dut.pc, 32'h0);
        check("reset_state", 32'(dut.state), 32'h0);
        check("reset_tv",    test_value, 32'h0);
        check("reset_regs",  reg_or_all(), 32'h0);
        check("reset_ir",    dut.ir, 32'h0);
        check("reset_aluout", dut.alu_out, 32'h0);

        // ALU and branch sequence
        clear_prog();
        prog[0]  = 32'h20020005; prog[1]  = 32'h2003000c; prog[2]  = 32'h2067fff7;
        prog[3]  = 32'h00e22025; prog[4]  = 32'h00642824; prog[5]  = 32'h00a42820;
        prog[6]  = 32'h10a7000a; prog[7]  = 32'h0064202a; prog[8]  = 32'h10800004;
        prog[9]  = 32'h00e22025; prog[10] = 32'h00642824; prog[11] = 32'h00a42820;
        prog[12] = 32'h20050000; prog[13] = 32'h00e2202a;
        start_prog();
        run(27);
        check("beq_not_taken_pc", dut.pc, 32'h1c);
        check("or_r4",  dut.rf.regs[4], 32'd7);
        check("add_r5", dut.rf.regs[5], 32'd11);
        check("addi_neg_r7", dut.rf.regs[7], 32'd3);
        run(7);
        check("beq_taken_pc", dut.pc, 32'h34);
        check("slt_false_r4", dut.rf.regs[4], 32'd0);
        run(4);
        check("seq_end_pc", dut.pc, 32'h38);
        check("seq_state",  32'(dut.state), 32'h0);
        check("r2", dut.rf.regs[2], 32'd5);
        check("r3", dut.rf.regs[3], 32'd12);
        check("r7", dut.rf.regs[7], 32'd3);
        check("slt_true_r4", dut.rf.regs[4], 32'd1);
        check("skipped_r5",  dut.rf.regs[5], 32'd11);
        check("r0_zero", dut.rf.regs[0], 32'd0);

        // Memory round trip through 0x54
        clear_prog();
        prog[0] = 32'h20020007; prog[1] = 32'hac020054; prog[2] = 32'h8c030054;
        start_prog();
        run(7);
        check("sw_before_edge_tv", test_value, 32'h0);
        run(1);
        check("sw_tv", test_value, 32'd7);
        run(4);
        check("lw_4cyc_r3", dut.rf.regs[3], 32'h0);
        run(1);
        check("lw_5cyc_r3", dut.rf.regs[3], 32'd7);
        check("lw_pc", dut.pc, 32'hc);
        check("lw_state", 32'(dut.state), 32'h0);

        // Subtract to negative
        clear_prog();
        prog[0] = 32'h20020003; prog[1] = 32'h00022022;
        start_prog();
        run(8);
        check("sub_r4", dut.rf.regs[4], 32'hfffffffd);

        // Jump to 0x40
        clear_prog();
        prog[0] = 32'h08000010;
        start_prog();
`ifdef MUL_MIPS_JUMP_EN
        run(3);
        check("jump_pc", dut.pc, 32'h40);
        check("jump_state", 32'(dut.state), 32'h0);
`else
        run(2);
        check("jump_nop_pc", dut.pc, 32'h4);
        check("jump_nop_state", 32'(dut.state), 32'h0);
`endif

        // Reset asserted while sw sits in MEMWR
        clear_prog();
        prog[0] = 32'h20020007; prog[1] = 32'hac020054;
        start_prog();
        run(7);
        check("mid_pre_tv", test_value, 32'h0);
        rst = 1'b0;
        #1;
        check("mid_pc", dut.pc, 32'h0);
        check("mid_state", 32'(dut.state), 32'h0);
        check("mid_r2", dut.rf.regs[2], 32'h0);
        @(negedge clk);
        check("mid_tv", test_value, 32'h0);
        check("mid_mem54", dut.dm.mem[8'h54], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
